lc3_seq_ctrl: RTL and testbench

Control sequencer for the LC-3 datapath: a fetch/decode/execute FSM that drives the register-load, bus-gate and mux-select strobes. It consumes the branch-enable flag from the condition-code/BEN block and tells that block when to load CC and BEN. Supported opcodes: ADD, AND, NOT, BR, JMP, LDR, STR and PAUSE.

---
 rtl/lc3_seq_ctrl_if.sv | 33 +++
 rtl/lc3_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_lc3_seq_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_seq_ctrl_if.sv
// lc3_seq_ctrl_if: groups the control sequencer's datapath-facing signals.
// master = sequencer side (drives strobes and selects), slave = datapath side.
interface lc3_seq_ctrl_if;
  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       BEN;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic [1:0] ADDR2MUX;
  logic [1:0] ALUK;
  logic       Mem_OE, Mem_WE;
  logic [4:0] State;

  modport master (
    input  Run, Continue, Opcode, IR_5, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    output Mem_OE, Mem_WE, State
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    input  Mem_OE, Mem_WE, State
  );
endinterface

// File: rtl/lc3_seq_ctrl.sv
// lc3_seq_ctrl: LC-3 fetch/decode/execute control sequencer (Moore FSM with
// registered outputs). MEM_WAIT sets the SRAM strobe length (1-15 cycles).
// Optional macro PAUSE_IR_EN adds PAUSE_IR1/PAUSE_IR2 between S35 and S32 for
// instruction-by-instruction stepping with the Continue button.
module lc3_seq_ctrl #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic              clk,
  input  logic              Reset,
  lc3_seq_ctrl_if.master    bus
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  typedef enum logic [4:0] {
    S0        = 5'd0,
    S1        = 5'd1,
    S32       = 5'd2,
    S33       = 5'd3,
    S35       = 5'd4,
    S5        = 5'd5,
    S6        = 5'd6,
    S7        = 5'd7,
    PAUSE     = 5'd8,
    S9        = 5'd9,
`ifdef PAUSE_IR_EN
    PAUSE_IR1 = 5'd10,
    PAUSE_IR2 = 5'd11,
`endif
    S12       = 5'd12,
    S16       = 5'd16,
    S18       = 5'd18,
    S22       = 5'd22,
    S23       = 5'd23,
    S25       = 5'd25,
    S27       = 5'd27,
    HALTED    = 5'd31
  } state_e;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_oe, mem_we;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{mem_oe: 1'b1, mem_we: 1'b1, default: '0};

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctl_t       ctl_q, ctl_d;

  // Next state and wait counter.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      HALTED: if (bus.Run) state_d = S18;
      S18: begin
        state_d = S33;
        cnt_d   = '0;
      end
      S33: if (cnt_q == WAIT_LAST) state_d = S35; else cnt_d = cnt_q + 4'd1;
`ifdef PAUSE_IR_EN
      S35:       state_d = PAUSE_IR1;
      PAUSE_IR1: if (bus.Continue)  state_d = PAUSE_IR2;
      PAUSE_IR2: if (!bus.Continue) state_d = S32;
`else
      S35:       state_d = S32;
`endif
      S32: begin
        unique case (bus.Opcode)
          4'b0001: state_d = S1;
          4'b0101: state_d = S5;
          4'b1001: state_d = S9;
          4'b0000: state_d = S0;
          4'b1100: state_d = S12;
          4'b0110: state_d = S6;
          4'b0111: state_d = S7;
          4'b1101: state_d = PAUSE;
          default: state_d = S18;
        endcase
      end
      S1, S5, S9, S12, S22, S27: state_d = S18;
      S0:    state_d = bus.BEN ? S22 : S18;
      S6: begin
        state_d = S25;
        cnt_d   = '0;
      end
      S25: if (cnt_q == WAIT_LAST) state_d = S27; else cnt_d = cnt_q + 4'd1;
      S7:    state_d = S23;
      S23: begin
        state_d = S16;
        cnt_d   = '0;
      end
      S16: if (cnt_q == WAIT_LAST) state_d = S18; else cnt_d = cnt_q + 4'd1;
      PAUSE: if (bus.Continue) state_d = S18;
      default: state_d = HALTED;
    endcase
  end

  // Output decode of the upcoming state, so the registered outputs match State.
  always_comb begin
    ctl_d = CTL_IDLE;
    unique case (state_d)
      S18: begin
        ctl_d.gate_pc = 1'b1;
        ctl_d.ld_mar  = 1'b1;
        ctl_d.ld_pc   = 1'b1;
      end
      S33, S25: begin
        ctl_d.mem_oe = 1'b0;
        ctl_d.ld_mdr = (cnt_d == WAIT_LAST);
      end
      S35: begin
        ctl_d.gate_mdr = 1'b1;
        ctl_d.ld_ir    = 1'b1;
      end
      S32: ctl_d.ld_ben = 1'b1;
      S1, S5, S9: begin
        ctl_d.gate_alu = 1'b1;
        ctl_d.ld_reg   = 1'b1;
        ctl_d.ld_cc    = 1'b1;
        ctl_d.sr1mux   = 1'b1;
        ctl_d.sr2mux   = bus.IR_5;
        ctl_d.aluk     = (state_d == S1) ? 2'd0 : (state_d == S5) ? 2'd1 : 2'd2;
      end
      S22: begin
        ctl_d.addr2mux = 2'd2;
        ctl_d.pcmux    = 2'd2;
        ctl_d.ld_pc    = 1'b1;
      end
      S12: begin
        ctl_d.addr1mux = 1'b1;
        ctl_d.pcmux    = 2'd2;
        ctl_d.ld_pc    = 1'b1;
      end
      S6, S7: begin
        ctl_d.gate_marmux = 1'b1;
        ctl_d.ld_mar      = 1'b1;
        ctl_d.addr1mux    = 1'b1;
        ctl_d.addr2mux    = 2'd1;
      end
      S27: begin
        ctl_d.gate_mdr = 1'b1;
        ctl_d.ld_reg   = 1'b1;
        ctl_d.ld_cc    = 1'b1;
      end
      S23: begin
        ctl_d.aluk     = 2'd3;
        ctl_d.gate_alu = 1'b1;
        ctl_d.ld_mdr   = 1'b1;
      end
      S16: ctl_d.mem_we = 1'b0;
      default: ;
    endcase
  end

  // State, wait counter and output registers; reset forces HALTED immediately.
  always_ff @(posedge clk or negedge Reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!Reset) begin
      state_q <= HALTED;
      cnt_q   <= '0;
      ctl_q   <= CTL_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

  assign bus.LD_MAR     = ctl_q.ld_mar;
  assign bus.LD_MDR     = ctl_q.ld_mdr;
  assign bus.LD_IR      = ctl_q.ld_ir;
  assign bus.LD_BEN     = ctl_q.ld_ben;
  assign bus.LD_CC      = ctl_q.ld_cc;
  assign bus.LD_REG     = ctl_q.ld_reg;
  assign bus.LD_PC      = ctl_q.ld_pc;
  assign bus.GatePC     = ctl_q.gate_pc;
  assign bus.GateMDR    = ctl_q.gate_mdr;
  assign bus.GateALU    = ctl_q.gate_alu;
  assign bus.GateMARMUX = ctl_q.gate_marmux;
  assign bus.PCMUX      = ctl_q.pcmux;
  assign bus.DRMUX      = ctl_q.drmux;
  assign bus.SR1MUX     = ctl_q.sr1mux;
  assign bus.SR2MUX     = ctl_q.sr2mux;
  assign bus.ADDR1MUX   = ctl_q.addr1mux;
  assign bus.ADDR2MUX   = ctl_q.addr2mux;
  assign bus.ALUK       = ctl_q.aluk;
  assign bus.Mem_OE     = ctl_q.mem_oe;
  assign bus.Mem_WE     = ctl_q.mem_we;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_lc3_seq_ctrl.sv
// tb_lc3_seq_ctrl: two sequencers (MEM_WAIT=2 and 3) share one stimulus stream.
// A micro-sequence queue model predicts state and strobes; directed sequences
// pin the model with hand-written literal expectations.
module tb_lc3_seq_ctrl;

  localparam logic [4:0] C_S0 = 5'd0, C_S1 = 5'd1, C_S32 = 5'd2, C_S33 = 5'd3,
                         C_S35 = 5'd4, C_S5 = 5'd5, C_S6 = 5'd6, C_S7 = 5'd7,
                         C_PAUSE = 5'd8, C_S9 = 5'd9, C_S12 = 5'd12, C_S16 = 5'd16,
                         C_S18 = 5'd18, C_S22 = 5'd22, C_S23 = 5'd23, C_S25 = 5'd25,
                         C_S27 = 5'd27, C_HALT = 5'd31;
`ifdef PAUSE_IR_EN
  localparam logic [4:0] C_PIR1 = 5'd10, C_PIR2 = 5'd11;
`endif

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_oe, mem_we;
    logic [4:0] state;
  } obs_t;

  typedef struct packed {
    logic [4:0] st;
    logic       last;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic run, cont, ir5, ben;
  logic [3:0] opcode;

  always #5 clk = ~clk;

  lc3_seq_ctrl_if bus_a ();
  lc3_seq_ctrl_if bus_b ();

  assign bus_a.Run = run;  assign bus_a.Continue = cont; assign bus_a.Opcode = opcode;
  assign bus_a.IR_5 = ir5; assign bus_a.BEN = ben;
  assign bus_b.Run = run;  assign bus_b.Continue = cont; assign bus_b.Opcode = opcode;
  assign bus_b.IR_5 = ir5; assign bus_b.BEN = ben;

  lc3_seq_ctrl #(.MEM_WAIT(2)) dut_a (.clk(clk), .Reset(rst_n), .bus(bus_a.master));
  lc3_seq_ctrl #(.MEM_WAIT(3)) dut_b (.clk(clk), .Reset(rst_n), .bus(bus_b.master));

  obs_t got_a, got_b;
  assign got_a = {bus_a.LD_MAR, bus_a.LD_MDR, bus_a.LD_IR, bus_a.LD_BEN, bus_a.LD_CC,
                  bus_a.LD_REG, bus_a.LD_PC, bus_a.GatePC, bus_a.GateMDR, bus_a.GateALU,
                  bus_a.GateMARMUX, bus_a.PCMUX, bus_a.DRMUX, bus_a.SR1MUX, bus_a.SR2MUX,
                  bus_a.ADDR1MUX, bus_a.ADDR2MUX, bus_a.ALUK, bus_a.Mem_OE, bus_a.Mem_WE,
                  bus_a.State};
  assign got_b = {bus_b.LD_MAR, bus_b.LD_MDR, bus_b.LD_IR, bus_b.LD_BEN, bus_b.LD_CC,
                  bus_b.LD_REG, bus_b.LD_PC, bus_b.GatePC, bus_b.GateMDR, bus_b.GateALU,
                  bus_b.GateMARMUX, bus_b.PCMUX, bus_b.DRMUX, bus_b.SR1MUX, bus_b.SR2MUX,
                  bus_b.ADDR1MUX, bus_b.ADDR2MUX, bus_b.ALUK, bus_b.Mem_OE, bus_b.Mem_WE,
                  bus_b.State};

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model: micro-sequence queues ----------------
  ent_t mq [2][$];
  ent_t cur_m [2];
  logic ir5_m [2];

  task automatic push(input int k, input logic [4:0] st, input logic last);
    mq[k].push_back(ent_t'{st, last});
  endtask

  task automatic push_wait(input int k, input logic [4:0] st, input int w);
    for (int i = 0; i < w; i++) push(k, st, i == w - 1);
  endtask

  task automatic push_fetch(input int k, input int w);
    push(k, C_S18, 1'b0);
    push_wait(k, C_S33, w);
    push(k, C_S35, 1'b0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      cur_m[k] = ent_t'{C_HALT, 1'b0};
      ir5_m[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input int w);
    ent_t nx;
    logic have;
    have = 1'b0;
    nx   = cur_m[k];
    case (cur_m[k].st)
      C_HALT:  if (!run)  have = 1'b1;
      C_PAUSE: if (!cont) have = 1'b1;
`ifdef PAUSE_IR_EN
      C_S35:  begin nx = ent_t'{C_PIR1, 1'b0}; have = 1'b1; end
      C_PIR1: begin nx = ent_t'{cont ? C_PIR2 : C_PIR1, 1'b0}; have = 1'b1; end
      C_PIR2: begin nx = ent_t'{cont ? C_PIR2 : C_S32, 1'b0}; have = 1'b1; end
`else
      C_S35:  begin nx = ent_t'{C_S32, 1'b0}; have = 1'b1; end
`endif
      C_S32: begin
        ir5_m[k] = ir5;
        case (opcode)
          4'd1:  push(k, C_S1, 1'b0);
          4'd5:  push(k, C_S5, 1'b0);
          4'd9:  push(k, C_S9, 1'b0);
          4'd0:  push(k, C_S0, 1'b0);
          4'd12: push(k, C_S12, 1'b0);
          4'd6:  begin push(k, C_S6, 1'b0); push_wait(k, C_S25, w); push(k, C_S27, 1'b0); end
          4'd7:  begin push(k, C_S7, 1'b0); push(k, C_S23, 1'b0); push_wait(k, C_S16, w); end
          4'd13: begin nx = ent_t'{C_PAUSE, 1'b0}; have = 1'b1; end
          default: ;
        endcase
      end
      C_S0: if (ben) push(k, C_S22, 1'b0);
      default: ;
    endcase
    if (!have) begin
      if (mq[k].size() == 0) push_fetch(k, w);
      nx = mq[k].pop_front();
    end
    cur_m[k] = nx;
  endtask

  function automatic obs_t exp_out(input ent_t e, input logic sr2);
    obs_t o;
    o = '0;
    o.mem_oe = 1'b1;
    o.mem_we = 1'b1;
    o.state  = e.st;
    case (e.st)
      C_S18: begin o.gate_pc = 1'b1; o.ld_mar = 1'b1; o.ld_pc = 1'b1; end
      C_S33, C_S25: begin o.mem_oe = 1'b0; o.ld_mdr = e.last; end
      C_S35: begin o.gate_mdr = 1'b1; o.ld_ir = 1'b1; end
      C_S32: o.ld_ben = 1'b1;
      C_S1, C_S5, C_S9: begin
        o.gate_alu = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1; o.sr1mux = 1'b1; o.sr2mux = sr2;
        o.aluk = (e.st == C_S1) ? 2'd0 : (e.st == C_S5) ? 2'd1 : 2'd2;
      end
      C_S22: begin o.addr2mux = 2'd2; o.pcmux = 2'd2; o.ld_pc = 1'b1; end
      C_S12: begin o.addr1mux = 1'b1; o.pcmux = 2'd2; o.ld_pc = 1'b1; end
      C_S6, C_S7: begin o.gate_marmux = 1'b1; o.ld_mar = 1'b1; o.addr1mux = 1'b1; o.addr2mux = 2'd1; end
      C_S27: begin o.gate_mdr = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1; end
      C_S23: begin o.aluk = 2'd3; o.gate_alu = 1'b1; o.ld_mdr = 1'b1; end
      C_S16: o.mem_we = 1'b0;
      default: ;
    endcase
    return o;
  endfunction

  // Model advances on the same edges as the DUTs.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        model_step(0, 2);
        model_step(1, 3);
      end
    end
  end

  // Compare process: every falling edge, both DUTs against the model.
  logic chk_en = 1'b0;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model_a", 32'(got_a), 32'(exp_out(cur_m[0], ir5_m[0])));
      check("model_b", 32'(got_b), 32'(exp_out(cur_m[1], ir5_m[1])));
    end
  end

  // ---------------- directed helpers ----------------
  obs_t tr_a [32];
  obs_t tr_b [32];
  int   exp_seq [$];

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic trace(input int n);
    run = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tr_a[i] = got_a;
      tr_b[i] = got_b;
      run = 1'b0;
    end
  endtask

  task automatic check_seq(input string nm, input logic use_b);
    for (int i = 0; i < exp_seq.size(); i++)
      check(nm, 32'(use_b ? tr_b[i].state : tr_a[i].state), 32'(exp_seq[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    rst_n = 1'b0; run = 1'b0; cont = 1'b0; opcode = 4'd0; ir5 = 1'b0; ben = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    do_reset();
    check("reset_outputs", 32'(got_a), 32'h0000_007F);

`ifndef PAUSE_IR_EN
    // ADD with immediate
    opcode = 4'b0001; ir5 = 1'b1;
    trace(7);
    exp_seq = {18, 3, 3, 4, 2, 1, 18};
    check_seq("add_seq", 1'b0);
    for (int i = 0; i < 7; i++) check("add_ld_mdr", 32'(tr_a[i].ld_mdr), (i == 2) ? 32'd1 : 32'd0);
    check("add_sr2mux", 32'(tr_a[5].sr2mux), 32'd1);
    check("add_aluk", 32'(tr_a[5].aluk), 32'd0);
    check("add_ld_cc", 32'(tr_a[5].ld_cc), 32'd1);

    // BR taken
    do_reset();
    opcode = 4'b0000; ben = 1'b1; ir5 = 1'b0;
    trace(8);
    exp_seq = {18, 3, 3, 4, 2, 0, 22, 18};
    check_seq("br_taken_seq", 1'b0);
    check("br_taken_pcmux", 32'(tr_a[6].pcmux), 32'd2);
    check("br_taken_ld_pc", 32'(tr_a[6].ld_pc), 32'd1);

    // BR not taken
    do_reset();
    ben = 1'b0;
    trace(7);
    exp_seq = {18, 3, 3, 4, 2, 0, 18};
    check_seq("br_nt_seq", 1'b0);
    check("br_nt_ld_pc", 32'(tr_a[5].ld_pc), 32'd0);

    // STR on the MEM_WAIT=3 instance
    do_reset();
    opcode = 4'b0111;
    trace(12);
    exp_seq = {18, 3, 3, 3, 4, 2, 7, 23, 16, 16, 16, 18};
    check_seq("str_seq", 1'b1);
    cnt = 0;
    for (int i = 0; i < 12; i++) if (tr_b[i].mem_we == 1'b0) cnt++;
    check("str_we_cycles", 32'(cnt), 32'd3);
    cnt = 0;
    for (int i = 6; i < 12; i++) if (tr_b[i].mem_oe == 1'b1) cnt++;
    check("str_oe_high", 32'(cnt), 32'd6);

    // PAUSE held, then released
    do_reset();
    opcode = 4'b1101; cont = 1'b0;
    trace(16);
    exp_seq = {18, 3, 3, 4, 2, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8};
    check_seq("pause_hold", 1'b0);
    cont = 1'b1;
    @(negedge clk);
    check("pause_release", 32'(got_a.state), 32'd18);
    cont = 1'b0;

    // Reset in the middle of S33
    do_reset();
    opcode = 4'b0001;
    trace(2);
    check("mid_s33", 32'(tr_a[1].state), 32'd3);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(got_a), 32'h0000_007F);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("run_after_reset", 32'(got_a.state), 32'd18);
`else
    // Stepping through PAUSE_IR with an illegal opcode
    opcode = 4'b1000; cont = 1'b0;
    trace(6);
    exp_seq = {18, 3, 3, 4, int'(C_PIR1), int'(C_PIR1)};
    check_seq("pir_hold", 1'b0);
    cont = 1'b1;
    @(negedge clk);
    check("pir2", 32'(got_a.state), 32'(C_PIR2));
    cont = 1'b0;
    @(negedge clk);
    check("pir_s32", 32'(got_a.state), 32'd2);
    @(negedge clk);
    check("illegal_s18", 32'(got_a.state), 32'd18);
    check("illegal_ld_reg", 32'(got_a.ld_reg), 32'd0);
`endif

    // Randomized run, checked cycle by cycle against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      run    = ($urandom_range(0, 7) == 0);
      cont   = ($urandom_range(0, 2) == 0);
      opcode = 4'($urandom_range(0, 15));
      ir5    = 1'($urandom_range(0, 1));
      ben    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
